uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter that converts bytes offered on a valid/ready handshake into asynchronous frames on `TxD`. Frames are 1 start bit, 8 data bits LSB first, an optional parity bit and 1 stop bit. The block is the transmit-side counterpart of the team's oversampling UART receiver and runs from the same system clock. A one-entry holding register lets the next byte be accepted while the current frame shifts out, so back-to-back frames go out with no idle gap.

## Interface
Parameters:
- `clk_freq`, default 50_000_000: system clock frequency in Hz.
- `baud_rate`, default 115200: line bit rate.
- `parity_odd`, default 0: parity sense (0 = even, 1 = odd). Used only when parity is compiled in.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `TxData`, input, 8: byte to send. Sampled only on a handshake.
- `valid_tx`, input, 1: `TxData` is valid.
- `ready_tx`, output, 1: the holding register is empty and can accept a byte.
- `TxD`, output, 1: serial line, idle high.
- `busy`, output, 1: a frame is being shifted, or the holding register is full.
- `tx_done`, output, 1: one-cycle pulse at the end of each stop bit.

## Operation
- `bit_div = clk_freq / baud_rate`, integer truncated. `bit_div >= 2` is an elaboration-time check. Bit counter width is `$clog2(bit_div)`.
- Handshake:
  - A byte is accepted on any rising edge with `valid_tx && ready_tx`. It is written to the holding register and `hold_full` is set.
  - `ready_tx = !hold_full`.
  - `valid_tx` while `ready_tx` is low is ignored; no data is lost or corrupted.
- Shifter FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: if `hold_full`, load the shifter from the holding register, clear `hold_full`, and go to START.
  - START: `TxD = 0` for `bit_div` cycles, then go to DATA.
  - DATA: drive bit `i` (LSB first) for `bit_div` cycles each. After bit 7, go to PARITY or STOP.
  - PARITY: drive the parity bit for `bit_div` cycles, then go to STOP.
  - STOP: `TxD = 1` for `bit_div` cycles. On the last cycle, pulse `tx_done`. If `hold_full`, reload and go directly to START on that same edge; otherwise go to IDLE.
- `TxD` is registered and glitch-free.
- `busy = (state != IDLE) || hold_full`.
- When the shifter loads on the same edge as a new handshake: the load uses the old holding contents, and the new byte is written to hold. This cannot occur because `ready_tx` is low while `hold_full`; it is listed for completeness.

## Timing
- Reset values (asynchronous, immediate): `TxD = 1`, `ready_tx = 1`, `busy = 0`, `tx_done = 0`. FSM goes to IDLE, counters are 0, hold is empty.
- Reset mid-frame aborts the frame. `TxD` returns high immediately and the pending held byte is discarded.
- Latency: handshake at edge E (shifter idle) → `TxD` falls after edge E+1.
- Frame length is exactly `10*bit_div` cycles, or `11*bit_div` with parity.
- Back-to-back: the next start bit begins on the edge after the last stop-bit cycle, with zero idle cycles.
- `ready_tx` rises on the edge after the shifter loads, so a second byte can be accepted during frame 1.
- `tx_done` is high for exactly one cycle, aligned with the final cycle of STOP.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is included, giving an 11-bit frame.
  - Parity bit = `^TxData ^ parity_odd`.
- Not defined:
  - No PARITY state, giving a 10-bit frame.
  - `parity_odd` is ignored and no parity logic is synthesized.

## Test plan
All scenarios use `clk_freq = 1_600_000` and `baud_rate = 100_000`, so `bit_div = 16`.
- Reset, then idle 100 cycles → `TxD = 1`, `ready_tx = 1`, `busy = 0`, no `tx_done`.
- Send 0xA5 → `TxD` low from E+1 for 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then high for 16 cycles. `tx_done` pulses once, 160 cycles after the start edge.
- Send 0x3C, then offer 0xFF while frame 1 is shifting → 0xFF is accepted once `ready_tx` rises. Its start bit follows the stop bit of 0x3C with zero gap. Two `tx_done` pulses, 160 cycles apart.
- Hold `valid_tx` with 0x11 while hold is full → exactly one extra frame is sent per handshake; no duplicate or dropped bytes.
- Assert `reset` in the middle of data bit 4 of 0x81 → `TxD = 1` immediately, `ready_tx = 1`, no `tx_done`. The next byte, 0x00, is sent as a clean frame.
- With `UART_TX_PARITY_EN` and `parity_odd = 0`, send 0x07 → parity bit 1 and a frame of 176 cycles. With `parity_odd = 1` → parity bit 0.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8-bit UART transmitter with one-entry holding register
// Optional parity bit compiled in with UART_TX_PARITY_EN (parity_odd selects the sense).
module uart_transmitter #(
    parameter int clk_freq   = 50_000_000,
    parameter int baud_rate  = 115200,
    parameter int parity_odd = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TxData,
    input  logic       valid_tx,
    output logic       ready_tx,
    output logic       TxD,
    output logic       busy,
    output logic       tx_done
);

    localparam int bit_div = clk_freq / baud_rate;
    localparam int cw      = (bit_div < 2) ? 1 : $clog2(bit_div);
    localparam logic [cw-1:0] cnt_last = cw'(bit_div - 1);

    generate
        if (bit_div < 2 || parity_odd < 0 || parity_odd > 1) begin : g_bad_cfg
            $error("uart_transmitter: bit_div must be >= 2 and parity_odd must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [cw-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shreg, shreg_n;
    logic [7:0]      hold_data;
    logic            hold_full, hold_full_n;
    logic            load, accept, last, txd_n;
`ifdef UART_TX_PARITY_EN
    logic            par_bit, par_n;
`endif

    assign accept   = valid_tx && ready_tx;
    assign last     = (cnt == cnt_last);
    assign ready_tx = !hold_full;
    assign busy     = (state != IDLE) || hold_full;
    assign tx_done  = (state == STOP) && last;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (last) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last) begin
                    state_n = STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (last) begin
                    cnt_n = '0;
                    // Reload straight into START so back-to-back frames have no idle gap.
                    if (hold_full) begin
                        load    = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        shreg_n = load ? hold_data : shreg;
`ifdef UART_TX_PARITY_EN
        par_n = load ? (^hold_data ^ (parity_odd != 0)) : par_bit;
`endif
        hold_full_n = accept ? 1'b1 : (load ? 1'b0 : hold_full);

        // Line level is computed from the next state so TxD can be a plain register.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[bit_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_n = par_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            hold_data <= 8'd0;
            hold_full <= 1'b0;
            TxD       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= shreg_n;
            hold_full <= hold_full_n;
            TxD       <= txd_n;
            if (accept) begin
                hold_data <= TxData;
            end
`ifdef UART_TX_PARITY_EN
            par_bit   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized self-checking bench for uart_transmitter
// Parity scenarios are built only when UART_TX_PARITY_EN is defined.
module tb_uart_transmitter;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BD       = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LEN = NBITS * BD;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] TxData;
    logic       valid_tx;
    logic       ready_tx, TxD, busy, tx_done;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;

    uart_transmitter #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .parity_odd(0)) dut (
        .clk(clk), .reset(reset), .TxData(TxData), .valid_tx(valid_tx),
        .ready_tx(ready_tx), .TxD(TxD), .busy(busy), .tx_done(tx_done)
    );

`ifdef UART_TX_PARITY_EN
    logic ready_o, txd_o, busy_o, done_o;
    uart_transmitter #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .parity_odd(1)) dut_odd (
        .clk(clk), .reset(reset), .TxData(TxData), .valid_tx(valid_tx),
        .ready_tx(ready_o), .TxD(txd_o), .busy(busy_o), .tx_done(done_o)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected line level for frame bit slot idx: start, d0..d7, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx, input int odd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && NBITS == 11) return logic'((($countones(b) + odd) % 2) != 0);
        return 1'b1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready_tx === 1'b1) begin
                TxData   = b;
                valid_tx = 1'b1;
                @(posedge clk);
                #1 valid_tx = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%02h ready_tx stayed %b, required 1", b, ready_tx);
        end
    endtask

    task automatic check_frame(input logic [7:0] b, input int max_wait,
                               output int waited, output int done_cyc);
        bit found = 0;
        int n;
        int bad_k = -1, bad_done = -1;
        logic exp, act;
        waited   = -1;
        done_cyc = -1;
        for (n = 0; n < max_wait; n++) begin
            @(negedge clk);
            if (TxD === 1'b0) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_start byte=%02h TxD=%b after %0d cycles, required 0", b, TxD, max_wait);
            return;
        end
        waited = n;
        for (int k = 0; k < LEN; k++) begin
            if (k > 0) @(negedge clk);
            exp = frame_bit(b, k / BD, 0);
            act = TxD;
`ifdef UART_TX_PARITY_EN
            if (act === exp && txd_o !== frame_bit(b, k / BD, 1)) begin
                exp = frame_bit(b, k / BD, 1);
                act = txd_o;
            end
`endif
            if (act !== exp && bad_k < 0) begin
                bad_k = k;
                $display("FAIL frame_bits byte=%02h cycle %0d line=%b, required %b", b, k, act, exp);
            end
            if (tx_done !== (k == LEN - 1) && bad_done < 0) begin
                bad_done = k;
                $display("FAIL tx_done byte=%02h cycle %0d tx_done=%b, required %b",
                         b, k, tx_done, (k == LEN - 1));
            end
            if (tx_done === 1'b1) done_cyc = cyc;
        end
        checks += 2;
        if (bad_k >= 0) errors++;
        if (bad_done >= 0) errors++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_tx = 1'b0;
        TxData = 8'h00;
        #1;
        checks += 4;
        if (TxD !== 1'b1)      begin errors++; $display("FAIL reset_txd TxD=%b, required 1", TxD); end
        if (ready_tx !== 1'b1) begin errors++; $display("FAIL reset_ready ready_tx=%b, required 1", ready_tx); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy busy=%b, required 0", busy); end
        if (tx_done !== 1'b0)  begin errors++; $display("FAIL reset_done tx_done=%b, required 0", tx_done); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (TxD !== 1'b1 || ready_tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL idle_quiet %0d bad idle cycles, required 0", bad);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] b, input bit check_latency);
        int w, d;
        send_byte(b);
        check_frame(b, 10, w, d);
        if (check_latency) begin
            checks++;
            if (w !== 1) begin
                errors++;
                $display("FAIL latency byte=%02h start seen after %0d negedges, required 1", b, w);
            end
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] b1, input logic [7:0] b2);
        int w1, d1, w2, d2;
        fork
            begin
                send_byte(b1);
                send_byte(b2);
            end
            begin
                check_frame(b1, 20, w1, d1);
                check_frame(b2, 5, w2, d2);
            end
        join
        checks += 2;
        if (w2 !== 0) begin
            errors++;
            $display("FAIL b2b_gap bytes=%02h/%02h idle gap=%0d, required 0", b1, b2, w2);
        end
        if (d2 - d1 !== LEN) begin
            errors++;
            $display("FAIL b2b_done_spacing spacing=%0d, required %0d", d2 - d1, LEN);
        end
    endtask

    task automatic test_hold_valid();
        int hs = 0, w, d, extra = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (i == 0) begin
                        TxData   = 8'h11;
                        valid_tx = 1'b1;
                    end
                    if (ready_tx === 1'b1) hs++;
                end
                @(negedge clk);
                valid_tx = 1'b0;
            end
            begin
                check_frame(8'h11, 20, w, d);
                check_frame(8'h11, 5, w, d);
            end
        join
        for (int i = 0; i < 2 * LEN; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || tx_done !== 1'b0) extra++;
        end
        checks += 2;
        // Hold is empty at first and frees once when the shifter loads; the next slot is past the window.
        if (hs !== 2) begin
            errors++;
            $display("FAIL hold_handshakes count=%0d, required 2", hs);
        end
        if (extra !== 0) begin
            errors++;
            $display("FAIL hold_no_extra_frame active cycles=%0d, required 0", extra);
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0, w, d;
        bit found = 0;
        send_byte(8'h81);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (TxD === 1'b0) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_frame_start TxD=%b, required 0", TxD);
        end
        fork
            repeat (5 * BD + BD / 2) @(negedge clk);
            send_byte(8'h5A);
        join
        checks++;
        if (TxD !== frame_bit(8'h81, 5, 0)) begin
            errors++;
            $display("FAIL rst_bit4 TxD=%b, required %b", TxD, frame_bit(8'h81, 5, 0));
        end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (TxD !== 1'b1)      begin errors++; $display("FAIL rst_mid_txd TxD=%b, required 1", TxD); end
        if (ready_tx !== 1'b1) begin errors++; $display("FAIL rst_mid_ready ready_tx=%b, required 1", ready_tx); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy busy=%b, required 0", busy); end
        if (tx_done !== 1'b0)  begin errors++; $display("FAIL rst_mid_done tx_done=%b, required 0", tx_done); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3 * BD; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_discard_hold active cycles=%0d, required 0", bad);
        end
        send_byte(8'h00);
        check_frame(8'h00, 10, w, d);
    endtask

    initial begin
        logic [7:0] r1, r2;
        test_reset();
        test_single(8'hA5, 1'b1);
        test_back_to_back(8'h3C, 8'hFF);
        test_hold_valid();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_single(8'h07, 1'b1);
`endif
        for (int i = 0; i < 4; i++) begin
            r1 = 8'($urandom);
            test_single(r1, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            test_back_to_back(r1, r2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
